// File: rtl/riscv_execute_if.sv
// Execute-stage bus: ID/EX inputs, forwarding sources, redirect/stall and EX/MEM outputs.
interface riscv_execute_if #(
    parameter int unsigned XLEN = 32
);
    // ID/EX register contents
    logic            i_valid_e;
    logic            i_reg_write_e;
    logic [1:0]      i_result_src_e;
    logic            i_mem_write_e;
    logic            i_branch_e;
    logic            i_jump_e;
    logic            i_jalr_e;
    logic            i_alu_src_e;
    logic [3:0]      i_alu_ctrl_e;
    logic [2:0]      i_funct3_e;
    logic [3:0]      i_byte_sel_e;
    logic [XLEN-1:0] i_rd1_e;
    logic [XLEN-1:0] i_rd2_e;
    logic [XLEN-1:0] i_pc_e;
    logic [XLEN-1:0] i_pc_plus_4e;
    logic [XLEN-1:0] i_ext_imm_e;
    logic [4:0]      i_rd_e;

    // Forwarding selects and sources
    logic [1:0]      i_forward_a_e;
    logic [1:0]      i_forward_b_e;
    logic [XLEN-1:0] i_alu_result_fwd_m;
    logic [XLEN-1:0] i_result_w;

    // Hazard / redirect
    logic            o_stall_e;
    logic            o_pc_src_e;
    logic [XLEN-1:0] o_pc_target_e;

    // EX/MEM register contents
    logic            o_reg_write_m;
    logic [1:0]      o_result_src_m;
    logic            o_mem_write_m;
    logic [XLEN-1:0] o_alu_result_m;
    logic [XLEN-1:0] o_write_data_m;
    logic [4:0]      o_rd_m;
    logic [XLEN-1:0] o_pc_plus_4m;
    logic [XLEN-1:0] o_ext_imm_m;
    logic [2:0]      o_funct3_m;
    logic [3:0]      o_byte_sel_m;

    modport master (
        output i_valid_e, i_reg_write_e, i_result_src_e, i_mem_write_e,
               i_branch_e, i_jump_e, i_jalr_e, i_alu_src_e, i_alu_ctrl_e,
               i_funct3_e, i_byte_sel_e, i_rd1_e, i_rd2_e, i_pc_e,
               i_pc_plus_4e, i_ext_imm_e, i_rd_e, i_forward_a_e,
               i_forward_b_e, i_alu_result_fwd_m, i_result_w,
        input  o_stall_e, o_pc_src_e, o_pc_target_e, o_reg_write_m,
               o_result_src_m, o_mem_write_m, o_alu_result_m, o_write_data_m,
               o_rd_m, o_pc_plus_4m, o_ext_imm_m, o_funct3_m, o_byte_sel_m
    );

    modport slave (
        input  i_valid_e, i_reg_write_e, i_result_src_e, i_mem_write_e,
               i_branch_e, i_jump_e, i_jalr_e, i_alu_src_e, i_alu_ctrl_e,
               i_funct3_e, i_byte_sel_e, i_rd1_e, i_rd2_e, i_pc_e,
               i_pc_plus_4e, i_ext_imm_e, i_rd_e, i_forward_a_e,
               i_forward_b_e, i_alu_result_fwd_m, i_result_w,
        output o_stall_e, o_pc_src_e, o_pc_target_e, o_reg_write_m,
               o_result_src_m, o_mem_write_m, o_alu_result_m, o_write_data_m,
               o_rd_m, o_pc_plus_4m, o_ext_imm_m, o_funct3_m, o_byte_sel_m
    );
endinterface

// File: rtl/riscv_execute.sv
// RV32 execute stage: forwarding, ALU, branch resolution, iterative divider, EX/MEM register.
module riscv_execute #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    riscv_execute_if.slave  bus
);
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_t;

    div_state_t state, state_next;

    logic [XLEN-1:0]  src_a, src_b, write_data, alu_result;
    logic             cond;
    logic             is_div, div_valid, op_signed, op_rem;
    logic [XLEN-1:0]  abs_a, abs_b;

    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  quo_q, rem_q, dvs_q, dividend_q;
    logic             rem_sel_q, neg_q_q, neg_r_q, div_zero_q;
    logic [XLEN:0]    rem_shift, diff;
    logic [XLEN-1:0]  div_result;

    // Forwarding muxes for both operands
    always_comb begin
        src_a = bus.i_rd1_e;
        write_data = bus.i_rd2_e;
        case (bus.i_forward_a_e)
            2'b01:   src_a = bus.i_result_w;
            2'b10:   src_a = bus.i_alu_result_fwd_m;
            default: src_a = bus.i_rd1_e;
        endcase
        case (bus.i_forward_b_e)
            2'b01:   write_data = bus.i_result_w;
            2'b10:   write_data = bus.i_alu_result_fwd_m;
            default: write_data = bus.i_rd2_e;
        endcase
    end

    assign src_b = bus.i_alu_src_e ? bus.i_ext_imm_e : write_data;

    // Single-cycle ALU; divide ops produce nothing here (handled by the divider)
    always_comb begin
        alu_result = '0;
        case (bus.i_alu_ctrl_e)
            4'd0:    alu_result = src_a + src_b;
            4'd1:    alu_result = src_a - src_b;
            4'd2:    alu_result = src_a & src_b;
            4'd3:    alu_result = src_a | src_b;
            4'd4:    alu_result = src_a ^ src_b;
            4'd5:    alu_result = XLEN'($signed(src_a) < $signed(src_b));
            4'd6:    alu_result = XLEN'(src_a < src_b);
            4'd7:    alu_result = src_a << src_b[4:0];
            4'd8:    alu_result = src_a >> src_b[4:0];
            4'd9:    alu_result = $unsigned($signed(src_a) >>> src_b[4:0]);
            default: alu_result = '0;
        endcase
    end

    // Branch condition from funct3, compared on forwarded rs1/rs2
    always_comb begin
        cond = 1'b0;
        case (bus.i_funct3_e)
            3'b000:  cond = (src_a == write_data);
            3'b001:  cond = (src_a != write_data);
            3'b100:  cond = ($signed(src_a) < $signed(write_data));
            3'b101:  cond = ($signed(src_a) >= $signed(write_data));
            3'b110:  cond = (src_a < write_data);
            3'b111:  cond = (src_a >= write_data);
            default: cond = 1'b0;
        endcase
    end

    assign bus.o_pc_src_e    = bus.i_valid_e & (bus.i_jump_e | (bus.i_branch_e & cond));
    assign bus.o_pc_target_e = bus.i_jalr_e ? ((src_a + bus.i_ext_imm_e) & ~XLEN'(1))
                                            : (bus.i_pc_e + bus.i_ext_imm_e);

    assign is_div    = (bus.i_alu_ctrl_e >= 4'd10) && (bus.i_alu_ctrl_e <= 4'd13);
    assign div_valid = bus.i_valid_e & is_div;
    assign op_signed = (bus.i_alu_ctrl_e == 4'd10) || (bus.i_alu_ctrl_e == 4'd12);
    assign op_rem    = (bus.i_alu_ctrl_e == 4'd12) || (bus.i_alu_ctrl_e == 4'd13);
    assign abs_a     = (op_signed && src_a[XLEN-1]) ? (~src_a + XLEN'(1)) : src_a;
    assign abs_b     = (op_signed && src_b[XLEN-1]) ? (~src_b + XLEN'(1)) : src_b;

    // Stall drops with reset so the hazard unit releases at once
    assign bus.o_stall_e = i_rstn & div_valid & (state != DONE);

    // Divider state register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_next;
    end

    // Divider next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (div_valid) state_next = BUSY;
            BUSY:    if (cnt == '1) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One restoring shift/subtract step
    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign diff      = rem_shift - {1'b0, dvs_q};

    // Divider datapath: latch operands on issue, iterate while busy
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt        <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            dividend_q <= '0;
            rem_sel_q  <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (state == IDLE && div_valid) begin
            cnt        <= '0;
            quo_q      <= abs_a;
            rem_q      <= '0;
            dvs_q      <= abs_b;
            dividend_q <= src_a;
            rem_sel_q  <= op_rem;
            neg_q_q    <= op_signed & (src_a[XLEN-1] ^ src_b[XLEN-1]);
            neg_r_q    <= op_signed & src_a[XLEN-1];
            div_zero_q <= (src_b == '0);
        end else if (state == BUSY) begin
            cnt   <= cnt + CNT_W'(1);
            quo_q <= {quo_q[XLEN-2:0], ~diff[XLEN]};
            rem_q <= diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
        end
    end

    // Final divide result with zero-divisor handling and sign fix-up
    always_comb begin
        div_result = '0;
        if (div_zero_q)
            div_result = rem_sel_q ? dividend_q : '1;
        else if (rem_sel_q)
            div_result = neg_r_q ? (~rem_q + XLEN'(1)) : rem_q;
        else
            div_result = neg_q_q ? (~quo_q + XLEN'(1)) : quo_q;
    end

    // EX/MEM pipeline register; bubble while the divider holds the front end
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            bus.o_reg_write_m  <= 1'b0;
            bus.o_result_src_m <= '0;
            bus.o_mem_write_m  <= 1'b0;
            bus.o_alu_result_m <= '0;
            bus.o_write_data_m <= '0;
            bus.o_rd_m         <= '0;
            bus.o_pc_plus_4m   <= '0;
            bus.o_ext_imm_m    <= '0;
            bus.o_funct3_m     <= '0;
            bus.o_byte_sel_m   <= '0;
        end else if (bus.o_stall_e) begin
            bus.o_reg_write_m  <= 1'b0;
            bus.o_result_src_m <= '0;
            bus.o_mem_write_m  <= 1'b0;
            bus.o_alu_result_m <= '0;
            bus.o_write_data_m <= '0;
            bus.o_rd_m         <= '0;
            bus.o_pc_plus_4m   <= '0;
            bus.o_ext_imm_m    <= '0;
            bus.o_funct3_m     <= '0;
            bus.o_byte_sel_m   <= '0;
        end else begin
            bus.o_reg_write_m  <= bus.i_reg_write_e;
            bus.o_result_src_m <= bus.i_result_src_e;
            bus.o_mem_write_m  <= bus.i_mem_write_e;
            bus.o_alu_result_m <= (state == DONE) ? div_result : alu_result;
            bus.o_write_data_m <= write_data;
            bus.o_rd_m         <= bus.i_rd_e;
            bus.o_pc_plus_4m   <= bus.i_pc_plus_4e;
            bus.o_ext_imm_m    <= bus.i_ext_imm_e;
            bus.o_funct3_m     <= bus.i_funct3_e;
            bus.o_byte_sel_m   <= bus.i_byte_sel_e;
        end
    end
endmodule

// File: doc/riscv_execute.md
Name: riscv_execute

Overview:
- Execute stage of the 5-stage pipelined RV32 core. Sits between the ID/EX register and the memory stage, and owns the EX/MEM pipeline register that feeds the memory stage.
- Performs operand forwarding, ALU operations, branch/jump resolution and RV32M divide/remainder.
- Divide/remainder uses an iterative multi-cycle divider that stalls the front of the pipeline.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
i_clk  input  1  clock, all state rising-edge
i_rstn  input  1  asynchronous active-low reset
i_valid_e  input  1  EX holds a real instruction; 0 = bubble
i_reg_write_e  input  1  register-file write enable
i_result_src_e  input  2  writeback result select, passed through
i_mem_write_e  input  1  data memory write enable
i_branch_e  input  1  conditional branch
i_jump_e  input  1  JAL/JALR
i_jalr_e  input  1  JALR (target base is forwarded rs1)
i_alu_src_e  input  1  0 = srcB is forwarded rs2, 1 = srcB is immediate
i_alu_ctrl_e  input  4  ALU op, encoding in Behaviour
i_funct3_e  input  3  branch condition / memory access size
i_byte_sel_e  input  4  store byte lanes, passed through
i_rd1_e, i_rd2_e  input  XLEN  register-file read data
i_pc_e, i_pc_plus_4e, i_ext_imm_e  input  XLEN  PC, PC+4, extended immediate
i_rd_e  input  5  destination register
i_forward_a_e, i_forward_b_e  input  2  00 = register file, 01 = i_result_w, 10 = i_alu_result_fwd_m, 11 = register file
i_alu_result_fwd_m  input  XLEN  ALU result forwarded from the memory stage
i_result_w  input  XLEN  writeback result
o_stall_e  output  1  divider busy; hazard unit holds PC, IF/ID and ID/EX
o_pc_src_e  output  1  redirect fetch
o_pc_target_e  output  XLEN  redirect address
o_reg_write_m, o_result_src_m[1:0], o_mem_write_m, o_alu_result_m, o_write_data_m, o_rd_m[4:0], o_pc_plus_4m, o_ext_imm_m, o_funct3_m[2:0], o_byte_sel_m[3:0]  output  -  EX/MEM register contents

Behaviour:
- Reset (async, i_rstn=0): all EX/MEM outputs 0, divider state IDLE, counter 0, o_stall_e 0.
- srcA = forward mux A. writeData = forward mux B. srcB = i_alu_src_e ? i_ext_imm_e : writeData.
- ALU ops:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT, 6 SLTU: result is 1 or 0.
  - 7 SLL, 8 SRL, 9 SRA: shift amount is srcB[4:0].
  - 10 DIV, 11 DIVU, 12 REM, 13 REMU.
  - 14, 15 reserved: result 0.
  - All arithmetic is mod 2^32.
- Branch/jump (combinational, same cycle):
  - Branch conditions by i_funct3_e: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; other codes are never taken.
  - o_pc_src_e = i_valid_e & (i_jump_e | (i_branch_e & cond)).
  - o_pc_target_e = i_jalr_e ? ((srcA + imm) & ~1) : (i_pc_e + imm).
- Non-divide instructions: EX/MEM captures every cycle, latency 1.
- Divider FSM, states IDLE / BUSY / DONE:
  - IDLE -> BUSY: when i_valid_e and the op is 10-13. Latch srcA, srcB and op; take absolute values for signed ops; counter = 0.
  - BUSY: one restoring shift/subtract step per cycle. Counter increments 0..31; at 31 go to DONE.
  - DONE: result selected (with sign fix-up) and presented to EX/MEM; next state IDLE.
- Stall and bubbles during a divide:
  - o_stall_e = divide op valid & state != DONE. It is combinational, so it asserts in the issue cycle.
  - The instruction occupies EX for exactly 34 cycles: 1 issue + 32 BUSY + 1 DONE. EX/MEM captures the result at the end of DONE.
  - While o_stall_e=1, EX/MEM loads a bubble: reg_write=0, mem_write=0, rd=0; data fields don't-care, driven 0.
- Divide special cases (fixed latency, no early exit):
  - Divide by zero: DIV/DIVU quotient = all-ones; REM/REMU remainder = dividend.
  - DIV 0x80000000 / -1: quotient 0x80000000, REM result 0.
  - Remainder takes the sign of the dividend.
- Latched operands make the divide immune to forwarding sources changing during BUSY.
- Reset mid-divide: the FSM returns to IDLE, the partial result is discarded, and stall drops immediately.
- A bubble (i_valid_e=0) never starts a divide or redirects fetch. Its control fields still pass into EX/MEM as given; the upstream register zeroes them.

Test Plan:
- ADD with rs1=5, rs2=7, forward 00 -> next cycle o_alu_result_m=12, o_rd_m and o_reg_write_m match the inputs.
- SUB with forward_a=10 (i_alu_result_fwd_m=100) and forward_b=01 (i_result_w=30) -> o_alu_result_m=70. BLT with -1 vs 1 at pc=0x40, imm=0x10 -> o_pc_src_e=1, o_pc_target_e=0x50.
- DIV -7/2 -> o_stall_e high for 33 cycles, 33 bubbles in EX/MEM, then quotient 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF.
- DIVU 10/0 -> 0xFFFFFFFF. REMU 10/0 -> 10. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. All three take 34 cycles.
- Deassert i_rstn at BUSY counter=15 -> all outputs 0 and o_stall_e=0 immediately. After release, a new DIVU 9/3 returns 3 correctly.
- JALR with srcA=0x101, imm=4 -> o_pc_target_e=0x104. Same instruction with i_valid_e=0 -> o_pc_src_e=0.
